// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: FIFO of retired {pc, inst} records streamed out as two 32-bit words per record
module trace_capture_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              clear,
  input  logic              cap_en,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_inst,
  output logic [31:0]       out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);
  typedef enum logic {PC, INST} phase_t;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  phase_t            phase;
  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic              push_req, push, pop, full, hs;
  assign full      = level == FULL_LVL;
  assign out_valid = level != '0;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && phase == INST;
  assign push_req  = cap_en && commit_valid;
  // a full buffer still takes a record when the head record leaves in the same cycle
  assign push      = push_req && (!full || pop);
  assign out_last  = out_valid && phase == INST;
  assign out_word  = !out_valid ? '0 : phase == INST ? inst_mem[head] : pc_mem[head];
  always_ff @(posedge clk_in) begin
    if (push && !clear) begin
      pc_mem[tail]   <= commit_pc;
      inst_mem[tail] <= commit_inst;
    end
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      phase      <= PC;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      phase      <= PC;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (hs) phase <= phase == PC ? INST : PC;
      if (push) tail <= tail + ADDR_W'(1);
      if (pop) head <= head + ADDR_W'(1);
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (push_req && !push) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end
endmodule
